// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for the R10K rename path.
//
// Dispatch pops one tag per cycle for a freshly renamed destination; retire pushes
// back the T_old released when the ROB head retires. The list holds
// DEPTH = PHYS_REGS - ARCH_REGS tags and comes out of reset holding
// p(ARCH_REGS)..p(PHYS_REGS-1), since p0..p(ARCH_REGS-1) back the initial map.
//
// Ports:
//   clock        in   single clock, all state updates on posedge
//   reset        in   asynchronous active-low reset
//   alloc_req    in   dispatch requests one tag this cycle
//   alloc_valid  out  list non-empty, alloc_tag is meaningful
//   alloc_tag    out  tag at the head of the list
//   alloc_ack    out  pop performed this cycle (alloc_req && alloc_valid)
//   free_en      in   retire releases a tag this cycle
//   free_tag     in   T_old from retire
//   free_count   out  number of tags currently in the list
//   full         out  free_count == DEPTH
//   error        out  sticky illegal-push flag, cleared only by reset
//
// Build option:
//   FREE_LIST_CHECK_EN  adds a PHYS_REGS-bit in_list bitmap; a push of a tag that is
//                       already in the list is a duplicate free, is dropped and sets
//                       error. Without it, duplicates are stored like any other tag.

module free_list #(
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          alloc_req,
  output logic                                          alloc_valid,
  output logic [$clog2(PHYS_REGS)-1:0]                  alloc_tag,
  output logic                                          alloc_ack,
  input  logic                                          free_en,
  input  logic [$clog2(PHYS_REGS)-1:0]                  free_tag,
  output logic [$clog2(PHYS_REGS-ARCH_REGS+1)-1:0]      free_count,
  output logic                                          full,
  output logic                                          error
);

  localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned TAG_W = $clog2(PHYS_REGS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // A one-entry list still needs a one-bit pointer to keep the vectors legal.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;

  // Per-cycle decode
  logic pop;
  logic push_legal;
  logic push_dup;
  logic push;

  // Wrap is an explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Outputs: purely from registered state (plus alloc_req for the ack).
  // No bypass from free_tag: a tag pushed into an empty list shows up next cycle.
  // --------------------------------------------------------------------------
  assign alloc_valid = (count_q != '0);
  assign alloc_tag   = storage_q[head_q];
  assign alloc_ack   = pop;
  assign free_count  = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign error       = error_q;

  assign pop        = alloc_req && alloc_valid;
  // Pushing into a full list is only safe when the head slot frees up this cycle.
  assign push_legal = !full || pop;
  assign push       = free_en && push_legal && !push_dup;

`ifdef FREE_LIST_CHECK_EN
  // --------------------------------------------------------------------------
  // Duplicate-free detection: one bit per physical tag, set while it is in the list.
  // --------------------------------------------------------------------------
  logic [PHYS_REGS-1:0] in_list_q, in_list_d;

  // Read before any same-cycle pop clears the bit, so freeing the tag being
  // popped this cycle still counts as a duplicate.
  assign push_dup = free_en && in_list_q[free_tag];

  always_comb begin
    in_list_d = in_list_q;
    if (pop) begin
      in_list_d[alloc_tag] = 1'b0;
    end
    if (push) begin
      in_list_d[free_tag] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PHYS_REGS); i++) begin
        in_list_q[i] <= (i >= int'(ARCH_REGS));
      end
    end else begin
      in_list_q <= in_list_d;
    end
  end
`else
  assign push_dup = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    error_d = error_q;

    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end

    unique case ({pop, push})
      2'b10:   count_d = count_q - CNT_W'(1);
      2'b01:   count_d = count_q + CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Overflow and (when enabled) duplicate frees are both dropped and flagged.
    if (free_en && !push) begin
      error_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Reset image: slot i holds p(ARCH_REGS+i).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        storage_q[i] <= TAG_W'(ARCH_REGS + i);
      end
    end else if (push) begin
      // When full with a simultaneous pop, tail == head: the old head value is
      // read combinationally this cycle before being overwritten at the edge.
      storage_q[tail_q] <= free_tag;
    end
  end

`ifndef SYNTHESIS
  // --------------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------------
  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count_q <= CNT_W'(DEPTH));

  a_head_bound: assert property (@(posedge clock) disable iff (!reset)
    32'(head_q) < DEPTH);

  a_tail_bound: assert property (@(posedge clock) disable iff (!reset)
    32'(tail_q) < DEPTH);

  // The occupied region always runs from head to tail.
  a_ptr_count: assert property (@(posedge clock) disable iff (!reset)
    ((32'(head_q) + 32'(count_q)) % DEPTH) == 32'(tail_q));

`ifdef FREE_LIST_CHECK_EN
  a_bitmap_count: assert property (@(posedge clock) disable iff (!reset)
    $countones(in_list_q) == 32'(count_q));
`endif
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. A queue holds the tags expected to come out of
// the list in order; frees push onto it, acknowledged pops take from its front.
module tb_free_list;

  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned DEPTH     = PHYS_REGS - ARCH_REGS;
  localparam int unsigned TAG_W     = $clog2(PHYS_REGS);
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_ack;
  logic             free_en;
  logic [TAG_W-1:0] free_tag;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             error;

  int checks = 0;
  int errors = 0;

  logic [TAG_W-1:0] sb_q [$];
  logic             model_err;

  free_list #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_tag  (alloc_tag),
    .alloc_ack  (alloc_ack),
    .free_en    (free_en),
    .free_tag   (free_tag),
    .free_count (free_count),
    .full       (full),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reset image of the scoreboard.
  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) sb_q.push_back(TAG_W'(ARCH_REGS + i));
    model_err = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic req, input logic fen, input logic [TAG_W-1:0] tag);
    @(negedge clock);
    alloc_req = req;
    free_en   = fen;
    free_tag  = tag;
    #1;
  endtask

  // Apply the current inputs to the scoreboard, as the next rising edge will.
  task automatic commit();
    bit pop, legal, dup;
    pop   = alloc_req && (sb_q.size() != 0);
    legal = (sb_q.size() < DEPTH) || pop;
    dup   = 1'b0;
`ifdef FREE_LIST_CHECK_EN
    foreach (sb_q[i]) if (sb_q[i] == free_tag) dup = 1'b1;
`endif
    if (pop) void'(sb_q.pop_front());
    if (free_en) begin
      if (!legal || dup) model_err = 1'b1;
      else sb_q.push_back(free_tag);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    alloc_req = 1'b0;
    free_en   = 1'b0;
    reset     = 1'b0;
    #2;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_tag  = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL rst_valid got=%b exp=1", alloc_valid); end
    checks++; if (alloc_tag !== TAG_W'(32)) begin errors++; $display("FAIL rst_tag got=%0d exp=32", alloc_tag); end
    checks++; if (alloc_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", alloc_ack); end
    checks++; if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL rst_count got=%0d exp=32", free_count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL rst_full got=%b exp=1", full); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", error); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, '0); commit(); end
    drive(1'b0, 1'b1, TAG_W'(3)); commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (free_count !== CNT_W'(30)) begin errors++; $display("FAIL mid_pre_count got=%0d exp=30", free_count); end
    // Assert reset away from any clock edge: the outputs must snap back at once.
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (alloc_tag !== TAG_W'(32)) begin errors++; $display("FAIL mid_tag got=%0d exp=32", alloc_tag); end
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got=%b exp=1", alloc_valid); end
    checks++; if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL mid_count got=%0d exp=32", free_count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", full); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL mid_error got=%b exp=0", error); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b1, 1'b0, '0);
      checks++; if (alloc_ack !== 1'b1) begin errors++; $display("FAIL drain_ack i=%0d got=%b exp=1", i, alloc_ack); end
      checks++; if (alloc_tag !== sb_q[0] || alloc_tag !== TAG_W'(32 + i)) begin
        errors++; $display("FAIL drain_tag i=%0d got=%0d exp=%0d", i, alloc_tag, 32 + i);
      end
      commit();
    end
    drive(1'b0, 1'b0, '0);
    checks++; if (free_count !== CNT_W'(0)) begin errors++; $display("FAIL drain_count got=%0d exp=0", free_count); end
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", alloc_valid); end
    drive(1'b1, 1'b0, '0);
    checks++; if (alloc_ack !== 1'b0) begin errors++; $display("FAIL empty_ack got=%b exp=0", alloc_ack); end
    commit();
  endtask

  // Starts from an empty list (after test_drain).
  task automatic test_empty_push();
    drive(1'b1, 1'b1, TAG_W'(5));
    checks++; if (alloc_ack !== 1'b0) begin errors++; $display("FAIL ep_ack got=%b exp=0", alloc_ack); end
    commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL ep_valid got=%b exp=1", alloc_valid); end
    checks++; if (alloc_tag !== TAG_W'(5)) begin errors++; $display("FAIL ep_tag got=%0d exp=5", alloc_tag); end
    checks++; if (free_count !== CNT_W'(1)) begin errors++; $display("FAIL ep_count got=%0d exp=1", free_count); end
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    drive(1'b1, 1'b1, TAG_W'(7));
    checks++; if (alloc_ack !== 1'b1) begin errors++; $display("FAIL fpp_ack got=%b exp=1", alloc_ack); end
    checks++; if (alloc_tag !== TAG_W'(32)) begin errors++; $display("FAIL fpp_tag got=%0d exp=32", alloc_tag); end
    commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL fpp_count got=%0d exp=32", free_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL fpp_error got=%b exp=0", error); end
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b0, '0);
      checks++; if (alloc_tag !== TAG_W'(33 + i)) begin errors++; $display("FAIL fpp_seq i=%0d got=%0d exp=%0d", i, alloc_tag, 33 + i); end
      commit();
    end
    drive(1'b0, 1'b0, '0);
    checks++; if (alloc_tag !== TAG_W'(7)) begin errors++; $display("FAIL fpp_wrap_tag got=%0d exp=7", alloc_tag); end
    checks++; if (free_count !== CNT_W'(1)) begin errors++; $display("FAIL fpp_wrap_count got=%0d exp=1", free_count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(1'b0, 1'b1, TAG_W'(9)); commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%b exp=1", error); end
    checks++; if (free_count !== CNT_W'(32)) begin errors++; $display("FAIL ovf_count got=%0d exp=32", free_count); end
    checks++; if (alloc_tag !== TAG_W'(32)) begin errors++; $display("FAIL ovf_tag got=%0d exp=32", alloc_tag); end
    drive(1'b1, 1'b0, '0); commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", error); end
    checks++; if (free_count !== CNT_W'(31)) begin errors++; $display("FAIL ovf_count2 got=%0d exp=31", free_count); end
  endtask

  // Pop 32 and 33, then free 32 twice (room for both, so only the bitmap can reject).
  task automatic test_dup_free();
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_err;
    apply_reset();
    drive(1'b1, 1'b0, '0); commit();
    drive(1'b1, 1'b0, '0); commit();
    drive(1'b0, 1'b1, TAG_W'(32)); commit();
    drive(1'b0, 1'b0, '0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL dup_first_err got=%b exp=0", error); end
    checks++; if (free_count !== CNT_W'(31)) begin errors++; $display("FAIL dup_first_count got=%0d exp=31", free_count); end
    drive(1'b0, 1'b1, TAG_W'(32)); commit();
    drive(1'b0, 1'b0, '0);
`ifdef FREE_LIST_CHECK_EN
    exp_cnt = CNT_W'(31);
    exp_err = 1'b1;
`else
    exp_cnt = CNT_W'(32);
    exp_err = 1'b0;
`endif
    checks++; if (error !== exp_err) begin errors++; $display("FAIL dup_second_err got=%b exp=%b", error, exp_err); end
    checks++; if (free_count !== exp_cnt) begin errors++; $display("FAIL dup_second_count got=%0d exp=%0d", free_count, exp_cnt); end
  endtask

  task automatic test_random();
    logic [TAG_W-1:0] pool [$];
    logic [TAG_W-1:0] tag;
    logic             req, fen;
    int               idx;
    apply_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req = ($urandom_range(0, 3) != 0);
      fen = ($urandom_range(0, 2) != 0);
      if (pool.size() != 0 && $urandom_range(0, 15) != 0) begin
        idx = $urandom_range(0, pool.size() - 1);
        tag = pool[idx];
        if (fen) pool.delete(idx);
      end else begin
        tag = TAG_W'($urandom_range(0, PHYS_REGS - 1));
      end
      drive(req, fen, tag);
      checks++; if (alloc_valid !== (sb_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, alloc_valid, sb_q.size() != 0);
      end
      checks++; if (alloc_ack !== (req && sb_q.size() != 0)) begin
        errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, alloc_ack, req && sb_q.size() != 0);
      end
      checks++; if (free_count !== CNT_W'(sb_q.size())) begin
        errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, free_count, sb_q.size());
      end
      checks++; if (full !== (sb_q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full, sb_q.size() == DEPTH);
      end
      checks++; if (error !== model_err) begin
        errors++; $display("FAIL rnd_error cyc=%0d got=%b exp=%b", cyc, error, model_err);
      end
      if (sb_q.size() != 0) begin
        checks++; if (alloc_tag !== sb_q[0]) begin
          errors++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, alloc_tag, sb_q[0]);
        end
        if (req) pool.push_back(sb_q[0]);
      end
      commit();
    end
    drive(1'b0, 1'b0, '0);
    checks++; if (free_count !== CNT_W'(sb_q.size())) begin
      errors++; $display("FAIL rnd_final_count got=%0d exp=%0d", free_count, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_drain();
    test_empty_push();
    test_full_pop_push();
    test_overflow();
    test_dup_free();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register tags for the R10K rename path.
- Dispatch pops one tag per cycle for a newly renamed destination.
- Retire pushes back the T_old released when the ROB head retires.
- Sits between the retire stage, which consumes the ROB retire outputs, and the dispatch/rename stage, which feeds the ROB its T/T_old pair.

Parameters:
- PHYS_REGS, 64, total physical registers; tag width is $clog2(PHYS_REGS).
- ARCH_REGS, 32, architectural registers; p0..p(ARCH_REGS-1) are mapped at reset.
- DEPTH (localparam), PHYS_REGS-ARCH_REGS, list capacity; need not be a power of two.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserted at 0, released synchronously by the system.
- alloc_req  in  1  dispatch requests one tag this cycle.
- alloc_valid  out  1  list non-empty; alloc_tag is meaningful.
- alloc_tag  out  $clog2(PHYS_REGS)  tag at head of list.
- alloc_ack  out  1  pop performed this cycle (alloc_req && alloc_valid).
- free_en  in  1  retire releases a tag this cycle.
- free_tag  in  $clog2(PHYS_REGS)  T_old from retire.
- free_count  out  $clog2(DEPTH+1)  number of tags currently in list.
- full  out  1  free_count == DEPTH.
- error  out  1  sticky illegal-push flag.

Behaviour:
- State:
  - storage[DEPTH] of tags;
  - head_ptr and tail_ptr, each $clog2(DEPTH) bits;
  - count, $clog2(DEPTH+1) bits;
  - error_q.
- Reset (async, reset==0):
  - storage[i] = ARCH_REGS+i for i in 0..DEPTH-1.
  - head_ptr=0, tail_ptr=0, count=DEPTH, error_q=0.
  - Resulting outputs: alloc_valid=1, alloc_tag=ARCH_REGS, alloc_ack=0, free_count=DEPTH, full=1, error=0.
- Outputs:
  - alloc_tag = storage[head_ptr]; alloc_valid = (count!=0); full = (count==DEPTH); free_count = count.
  - All combinational from registered state; no bypass from free_tag to alloc_tag.
- Pop (alloc_req && alloc_valid):
  - alloc_ack=1 combinationally in the same cycle; dispatch latches alloc_tag that cycle.
  - head_ptr advances on the next edge.
  - alloc_req while empty: alloc_ack=0, no state change.
- Push (free_en && push_legal):
  - storage[tail_ptr] <= free_tag; tail_ptr advances.
  - push_legal = !full || pop this cycle.
  - A push while full with no simultaneous pop is dropped and sets error_q.
- free_tag < ARCH_REGS is legal. Retire only presents tags that came from the map; no special zero-register handling.
- Pointer wrap: ptr == DEPTH-1 -> 0, else ptr+1. Wrap is explicit compare, never natural overflow.
- Count update per edge:
  - pop only: count-1;
  - push only: count+1;
  - both, or neither: unchanged.
- Empty with simultaneous push: no pop (alloc_valid=0). Tag is visible the next cycle.
- Full with simultaneous pop and push: both happen; count stays DEPTH.
- error_q clears only on reset.
- Reset mid-operation: immediate return to the reset image regardless of in-flight requests.

Optional Feature:
- FREE_LIST_CHECK_EN defined:
  - Adds a PHYS_REGS-bit in_list bitmap.
  - Reset value: bits ARCH_REGS..PHYS_REGS-1 set.
  - Pop clears the bit of alloc_tag; push sets the bit of free_tag.
  - A push of a tag whose bit is already set is a duplicate free. It is dropped (no storage, pointer or count update) and sets error_q.
  - If a pop of the same tag occurs that cycle, the bit is read before the pop clears it.
- Not defined:
  - No bitmap.
  - error_q is set only by overflow pushes.
  - Duplicate frees are stored as normal.

Test Plan:
- Reset with defaults -> alloc_valid=1, alloc_tag=32, free_count=32, full=1, error=0. Assert reset mid-stream -> same values the next sample, asynchronously.
- Pop on 32 consecutive cycles -> alloc_tag sequence 32..63, each with alloc_ack=1. Then free_count=0, alloc_valid=0; a 33rd alloc_req gives alloc_ack=0.
- From empty, free_en with free_tag=5 and alloc_req the same cycle -> alloc_ack=0 that cycle. Next cycle alloc_valid=1, alloc_tag=5, free_count=1.
- Full list, alloc_req and free_en(tag 7) in the same cycle -> pop of 32, count stays 32, error=0. After popping 31 more (33..63), alloc_tag=7, confirming wrap of tail_ptr and head_ptr.
- Full list, free_en(tag 9) with no pop -> dropped, error=1 sticky, free_count=32. Under FREE_LIST_CHECK_EN, popping tag 32 then freeing 32 twice -> first push accepted, second dropped with error=1.
- Random interleaved alloc/free over 10k cycles against a queue model -> alloc_tag order matches and free_count matches every cycle. Under FREE_LIST_CHECK_EN, no tag ever appears twice in the list.
